// File: rtl/encoder4x2_pipe.sv
// encoder4x2_pipe
//   Registered 4-to-2 priority encoder (highest index wins) with valid/ready
//   handshakes and a 2-entry FIFO output buffer. Flags zero-hot and multi-hot
//   words and keeps a saturating count of them.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake for the y0..y3 word
//   y0..y3                decoder lines, y[n] means code n
//   out_valid / out_ready output handshake for the head entry
//   a, b                  head code, a is the MSB
//   out_zero, out_multi   head word had no line / two or more lines set
//   err_cnt               saturating count of accepted zero/multi-hot words
module encoder4x2_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             y0,
    input  logic             y1,
    input  logic             y2,
    input  logic             y3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             a,
    output logic             b,
    output logic             out_zero,
    output logic             out_multi,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] code;
        logic       zero;
        logic       multi;
    } entry_t;

    state_t state_q, state_d;
    entry_t head_q, tail_q, enc;
    logic   live_q;
    logic   push, pop;
    logic   load_head_new, load_tail_new, load_head_tail;
    logic [2:0] hot_cnt;

    // Encode the incoming word; the result is what gets stored at push time.
    always_comb begin
        enc     = '0;
        hot_cnt = {2'b00, y0} + {2'b00, y1} + {2'b00, y2} + {2'b00, y3};
        if (y3)      enc.code = 2'b11;
        else if (y2) enc.code = 2'b10;
        else if (y1) enc.code = 2'b01;
        else         enc.code = 2'b00;
        enc.zero  = (hot_cnt == 3'd0);
        enc.multi = (hot_cnt > 3'd1);
    end

    // live_q keeps in_ready low while reset is held and until the first edge
    // after release; afterwards ready depends on the buffer state only.
    assign in_ready  = live_q && (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_head_new  = 1'b0;
        load_tail_new  = 1'b0;
        load_head_tail = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d       = ONE;
                    load_head_new = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_new = 1'b1;
                end else if (push) begin
                    state_d       = FULL;
                    load_tail_new = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d        = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head_new)       head_q <= enc;
            else if (load_head_tail) head_q <= tail_q;
            if (load_tail_new)       tail_q <= enc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (push && (enc.zero || enc.multi) && (err_cnt != '1)) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end

    // Head register is not cleared on the last pop, so mask it when empty.
    always_comb begin
        {a, b, out_zero, out_multi} = '0;
        if (out_valid) {a, b, out_zero, out_multi} = head_q;
    end

endmodule

// File: tb/tb_encoder4x2_pipe.sv
// tb_encoder4x2_pipe
//   Self-checking bench for encoder4x2_pipe: directed vector table, random
//   traffic against a queue-based reference model, reset and saturation cases.
module tb_encoder4x2_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic       y0, y1, y2, y3;
    logic       out_valid, out_ready;
    logic       a, b, out_zero, out_multi;
    logic [7:0] err_cnt;

    // Second instance with a 2-bit counter for the saturation case.
    logic       s_valid, s_ready_in, s_ready_out;
    logic [3:0] s_word;
    logic       s_out_valid, s_a, s_b, s_zero, s_multi;
    logic [1:0] s_err;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    encoder4x2_pipe #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .out_zero(out_zero), .out_multi(out_multi),
        .err_cnt(err_cnt)
    );

    encoder4x2_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_valid), .in_ready(s_ready_in),
        .y0(s_word[0]), .y1(s_word[1]), .y2(s_word[2]), .y3(s_word[3]),
        .out_valid(s_out_valid), .out_ready(s_ready_out),
        .a(s_a), .b(s_b), .out_zero(s_zero), .out_multi(s_multi),
        .err_cnt(s_err)
    );

    // Reference model: FIFO of raw words, encoding derived when read.
    logic [3:0] mq[$];
    int         m_err;
    bit         m_live;

    function automatic int top_index(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) if (w[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] h;
        bit         v;
        int         code;
        v    = (mq.size() != 0);
        h    = v ? mq[0] : 4'b0000;
        code = v ? top_index(h) : 0;
        chk("m_out_valid", int'(out_valid), int'(v));
        chk("m_in_ready", int'(in_ready), int'(m_live && mq.size() != 2));
        chk("m_code", int'({a, b}), code);
        chk("m_zero", int'(out_zero), int'(v && h == 4'b0000));
        chk("m_multi", int'(out_multi), int'(v && $countones(h) > 1));
        chk("m_err_cnt", int'(err_cnt), m_err);
    endtask

    // Call right after a negedge: drive, clock, update model, check at negedge.
    task automatic step(input logic v, input logic [3:0] w, input logic r);
        bit m_push, m_pop;
        in_valid = v;
        {y3, y2, y1, y0} = w;
        out_ready = r;
        m_push = v && m_live && (mq.size() < 2);
        m_pop  = (mq.size() > 0) && r;
        @(posedge clk);
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
            mq.push_back(w);
            if ($countones(w) != 1 && m_err < 255) m_err++;
        end
        m_live = 1'b1;
        @(negedge clk);
        check_model();
    endtask

    task automatic model_reset();
        mq.delete();
        m_err  = 0;
        m_live = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [3:0] w;
        logic       r;
        logic       ev;
        logic       er;
        logic [1:0] eab;
        logic       ez;
        logic       em;
        int         ecnt;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 4'b1010, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 2};
        tbl[6]  = '{1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 3};
        tbl[7]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3};
        tbl[8]  = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3};
        tbl[9]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 3};
        tbl[10] = '{1'b1, 4'b1000, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 3};
        tbl[11] = '{1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 3};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 3};
        tbl[13] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3};
        tbl[14] = '{1'b1, 4'b0010, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 3};
        tbl[15] = '{1'b1, 4'b1000, 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 3};
        tbl[16] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 3};

        rst_n = 1'b0;
        in_valid = 1'b0; {y3, y2, y1, y0} = 4'b0000; out_ready = 1'b0;
        s_valid = 1'b0; s_word = 4'b0000; s_ready_out = 1'b1;
        model_reset();

        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_code", int'({a, b, out_zero, out_multi}), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        rst_n = 1'b1;

        step(1'b0, 4'b0000, 1'b0);
        chk("ready_after_release", int'(in_ready), 1);

        // Directed vectors
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].w, tbl[i].r);
            chk($sformatf("t%0d_valid", i), int'(out_valid), int'(tbl[i].ev));
            chk($sformatf("t%0d_ready", i), int'(in_ready), int'(tbl[i].er));
            chk($sformatf("t%0d_code", i), int'({a, b}), int'(tbl[i].eab));
            chk($sformatf("t%0d_zero", i), int'(out_zero), int'(tbl[i].ez));
            chk($sformatf("t%0d_multi", i), int'(out_multi), int'(tbl[i].em));
            chk($sformatf("t%0d_err", i), int'(err_cnt), tbl[i].ecnt);
        end

        // Random traffic; long enough that the 8-bit counter saturates
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 4'($urandom % 16), ($urandom % 3) != 0);
        end
        chk("rand_err_saturated", int'(err_cnt), 255);

        // Reset mid-operation
        #2 rst_n = 1'b0;
        #1;
        chk("rst1_out_valid", int'(out_valid), 0);
        chk("rst1_err", int'(err_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        chk("full_ready", int'(in_ready), 0);
        chk("full_err", int'(err_cnt), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_out_valid", int'(out_valid), 0);
        chk("rst2_err", int'(err_cnt), 0);
        chk("rst2_code", int'({a, b, out_zero, out_multi}), 0);
        chk("rst2_in_ready", int'(in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 4'b0000, 1'b1);
        chk("post_rst_ready", int'(in_ready), 1);
        chk("post_rst_valid", int'(out_valid), 0);
        step(1'b0, 4'b0000, 1'b1);
        chk("post_rst_no_output", int'(out_valid), 0);

        // Saturation on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_word  = 4'b0000;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("sat%0d", i), int'(s_err), (i + 1 > 3) ? 3 : i + 1);
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("sat_pop_keeps", int'(s_err), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder4x2_pipe.md
# encoder4x2_pipe

Registered 4-to-2 priority encoder with a valid/ready handshake on both sides and a 2-entry output buffer. It is the inverse of the team's 2x4 decoder: it takes the four decoder lines `y0..y3` and recovers the 2-bit code `{a,b}`, with `a` as the MSB. It also flags zero-hot and multi-hot input words and counts them. It sits at the back end of the decoder path, so the encoded code can be checked against the original stimulus in loopback.

## Interface
Parameters:
- `CNT_W`, default 8: width of the error counter `err_cnt`.

Ports:
- `clk`, input, 1: the only clock; all logic is rising-edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: the `y0..y3` word is valid.
- `in_ready`, output, 1: the block can accept a word this cycle.
- `y0`, `y1`, `y2`, `y3`, input, 1 each: decoder lines; `y[n]` means code n.
- `out_valid`, output, 1: the head entry is valid.
- `out_ready`, input, 1: the consumer accepts the head entry.
- `a`, output, 1: code MSB.
- `b`, output, 1: code LSB.
- `out_zero`, output, 1: the head word had no line set.
- `out_multi`, output, 1: the head word had two or more lines set.
- `err_cnt`, output, CNT_W: saturating count of accepted zero-hot or multi-hot words.

## Operation
- Push: when `in_valid && in_ready`. Pop: when `out_valid && out_ready`.
- Encoding is evaluated at push time:
  - Priority is highest index first: y3 gives 11, y2 gives 10, y1 gives 01, y0 gives 00.
  - Zero-hot word: `{a,b}=00`, `out_zero=1`, `out_multi=0`.
  - Two or more lines set: the code of the highest set line, `out_multi=1`, `out_zero=0`.
  - Exactly one line set: both flags 0.
- Buffer state is the entry count:
  - EMPTY (0): push goes to ONE.
  - ONE (1): push without pop goes to FULL; pop without push goes to EMPTY; push and pop together stay in ONE, and the new word becomes the head.
  - FULL (2): pop goes to ONE; no push is possible.
- `in_ready = (count != 2)`. It is decoded from state only and has no combinational path from `out_ready`.
- `out_valid = (count != 0)`.
- Order is FIFO. The head is always the oldest entry.
- `a`, `b`, `out_zero` and `out_multi` show the head entry. They must stay stable while `out_valid=1 && out_ready=0`.
- When EMPTY, `a`, `b`, `out_zero` and `out_multi` are driven 0.
- `err_cnt` increments by 1 on each push whose word is zero-hot or multi-hot.
  - It saturates at 2^CNT_W−1 and never wraps.
  - Pops do not affect it.
  - It is cleared only by reset.
- Words presented while `in_ready=0` are ignored. They do not change state and are not counted.

## Timing
- Reset (`rst_n` low, taking effect asynchronously): count=0, `out_valid=0`, `a=b=0`, `out_zero=out_multi=0`, `err_cnt=0`.
- `in_ready` is held 0 while `rst_n=0`, and is 1 from the first cycle after release.
- Latency: a word pushed at edge k has `out_valid=1` with its code after edge k, provided the buffer was EMPTY. A consumer holding `out_ready=1` pops it at edge k+1.
- Throughput: one word per cycle with `out_ready` held high. The count oscillates 0↔1 or stays at 1.
- With the buffer FULL and `out_ready=1`: the pop happens at the edge, and `in_ready` rises in the next cycle. There is one bubble on the input side; this is required.
- Reset asserted mid-operation: all buffered entries are discarded immediately and the counter clears. No partial output may appear after release.

## Test plan
- One-hot sweep: push y0, y1, y2, y3 (0001, 0010, 0100, 1000) with `out_ready=1` → codes 00, 01, 10, 11 each one cycle after push; flags 0; `err_cnt=0`.
- Priority and errors: push 1010, then 0000, then 1111 → codes 11, 00, 11; flags multi, zero, multi respectively; `err_cnt=3`.
- Backpressure: `out_ready=0`, push 0010, 0100, then 1000 → `in_ready=0` after the second push; the third word is not accepted. Raise `out_ready` → pops give 01 then 10 in order, and the head is stable while stalled.
- Simultaneous push/pop in ONE: count 1 holding 01; push 1000 and pop together → count stays 1, head becomes 11.
- Saturation: `CNT_W=2`, push five zero-hot words → `err_cnt` reads 1, 2, 3, 3, 3.
- Reset mid-operation: FULL with `err_cnt=2`, assert `rst_n=0` between edges → immediately `out_valid=0` and `err_cnt=0`; after release, `in_ready=1` and EMPTY.
